// File: rtl/hex_page_scheduler.sv
// -----------------------------------------------------------------------------
// hex_page_scheduler
//   Drives the six DE1-SoC seven-segment digits. HEX4..HEX0 show one of three
//   pages (SoC output port low half, output port high half, switch input port).
//   HEX5 is a status digit (lockup > data-invalid > heartbeat). Pages advance on
//   a debounced push-button press or on an auto-rotate timer.
//
// Ports
//   CLOCK_50   in   1   system clock
//   HRESETn    in   1   asynchronous active-low reset
//   key_n      in   1   page-advance button, active-low, asynchronous
//   auto_en    in   1   auto-rotate enable, asynchronous
//   oPort      in   32  SoC output port
//   iPort      in   32  SoC input port
//   LOCKUP     in   1   CPU lockup flag
//   HEX0..HEX5 out  7   active-low segments {g,f,e,d,c,b,a}, registered
//   page       out  2   current page index 0..2, registered
// -----------------------------------------------------------------------------
module hex_page_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 100_000_000,
  parameter int HB_MSB          = 25
) (
  input  logic        CLOCK_50,
  input  logic        HRESETn,
  input  logic        key_n,
  input  logic        auto_en,
  input  logic [31:0] oPort,
  input  logic [31:0] iPort,
  input  logic        LOCKUP,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [1:0]  page
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_O     = 7'h23;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_WAIT = 2'd1,
    ST_HELD       = 2'd2,
    ST_REL_WAIT   = 2'd3
  } db_state_t;

  // Hex nibble to active-low segment pattern.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic              key_meta_r;
  logic              key_sync_r;
  logic              auto_meta_r;
  logic              auto_sync_r;
  logic [1:0]        settle_r;
  logic              armed_r;
  db_state_t         db_state_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic              press_r;
  logic [AUTO_W-1:0] auto_cnt_r;
  logic [HB_MSB:0]   hb_cnt_r;
  logic [1:0]        page_r;
  logic [6:0]        hex_r [6];

  logic              auto_pulse_s;
  logic              advance_s;
  logic [1:0]        page_nxt_s;
  logic [4:0][6:0]   dig_s;
  logic [6:0]        status_s;
  logic              heartbeat_s;
  logic              unused_ok_s;

  // iPort[31:20] is never displayed.
  assign unused_ok_s = ^iPort[31:20];

  // Two-flop synchronisers; reset to the idle levels of the inputs.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      key_meta_r  <= 1'b1;
      key_sync_r  <= 1'b1;
      auto_meta_r <= 1'b0;
      auto_sync_r <= 1'b0;
    end else begin
      key_meta_r  <= key_n;
      key_sync_r  <= key_meta_r;
      auto_meta_r <= auto_en;
      auto_sync_r <= auto_meta_r;
    end
  end

  // Arming: the synchroniser holds its reset value for a few cycles, so a key
  // already held at reset release must first be seen released before any
  // press is accepted.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end else begin
        settle_r <= settle_r;
      end
      armed_r <= armed_r | ((settle_r == 2'd3) & key_sync_r);
    end
  end

  // Debounce FSM with a single stability counter and a registered press pulse.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      db_state_r <= ST_IDLE;
      db_cnt_r   <= '0;
      press_r    <= 1'b0;
    end else begin
      case (db_state_r)
        ST_IDLE: begin
          press_r  <= 1'b0;
          db_cnt_r <= '0;
          if (armed_r && !key_sync_r) begin
            db_state_r <= ST_PRESS_WAIT;
          end else begin
            db_state_r <= ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (key_sync_r) begin
            db_state_r <= ST_IDLE;
            db_cnt_r   <= '0;
            press_r    <= 1'b0;
          end else if (db_cnt_r == DB_LAST) begin
            db_state_r <= ST_HELD;
            db_cnt_r   <= '0;
            press_r    <= 1'b1;
          end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
            press_r    <= 1'b0;
          end
        end
        ST_HELD: begin
          press_r  <= 1'b0;
          db_cnt_r <= '0;
          if (key_sync_r) begin
            db_state_r <= ST_REL_WAIT;
          end else begin
            db_state_r <= ST_HELD;
          end
        end
        ST_REL_WAIT: begin
          press_r <= 1'b0;
          if (!key_sync_r) begin
            db_state_r <= ST_HELD;
            db_cnt_r   <= '0;
          end else if (db_cnt_r == DB_LAST) begin
            db_state_r <= ST_IDLE;
            db_cnt_r   <= '0;
          end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
          end
        end
        default: begin
          db_state_r <= ST_IDLE;
          db_cnt_r   <= '0;
          press_r    <= 1'b0;
        end
      endcase
    end
  end

  // Auto-rotate timer; a manual press restarts the full period.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      auto_cnt_r <= '0;
    end else if (!auto_sync_r || press_r || auto_pulse_s) begin
      auto_cnt_r <= '0;
    end else begin
      auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
    end
  end

  // Free-running heartbeat counter.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      hb_cnt_r <= '0;
    end else begin
      hb_cnt_r <= hb_cnt_r + (HB_MSB + 1)'(1);
    end
  end

  // Next page: press and auto pulses in the same cycle count as one advance.
  always_comb begin
    auto_pulse_s = auto_sync_r & (auto_cnt_r == AUTO_LAST);
    advance_s    = press_r | auto_pulse_s;
    page_nxt_s   = page_r;
    if (advance_s) begin
      if (page_r == 2'd2) begin
        page_nxt_s = 2'd0;
      end else begin
        page_nxt_s = page_r + 2'd1;
      end
    end else begin
      page_nxt_s = page_r;
    end
  end

  // Digit decode uses the next page so a page change shows up with the page.
  always_comb begin
    dig_s = {5{SEG_BLANK}};
    case (page_nxt_s)
      2'd0: begin
        for (int i = 0; i < 5; i++) begin
          dig_s[i] = hex7(oPort[4*i +: 4]);
        end
      end
      2'd1: begin
        for (int i = 0; i < 3; i++) begin
          dig_s[i] = hex7(oPort[20 + 4*i +: 4]);
        end
      end
      2'd2: begin
        for (int i = 0; i < 5; i++) begin
          dig_s[i] = hex7(iPort[4*i +: 4]);
        end
      end
      default: dig_s = {5{SEG_BLANK}};
    endcase
  end

  // Status digit priority: lockup, then all-ones data, then heartbeat.
  always_comb begin
    heartbeat_s = hb_cnt_r[HB_MSB] & hb_cnt_r[HB_MSB-2];
    status_s    = SEG_BLANK;
    if (LOCKUP) begin
      status_s = SEG_L;
    end else if (oPort == 32'hFFFF_FFFF) begin
      status_s = SEG_E;
    end else if (heartbeat_s) begin
      status_s = SEG_O;
    end else begin
      status_s = SEG_BLANK;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      page_r <= 2'd0;
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= SEG_BLANK;
      end
    end else begin
      page_r <= page_nxt_s;
      for (int i = 0; i < 5; i++) begin
        hex_r[i] <= dig_s[i];
      end
      hex_r[5] <= status_s;
    end
  end

  assign page = page_r;
  assign HEX0 = hex_r[0];
  assign HEX1 = hex_r[1];
  assign HEX2 = hex_r[2];
  assign HEX3 = hex_r[3];
  assign HEX4 = hex_r[4];
  assign HEX5 = hex_r[5];

endmodule

// File: tb/tb_hex_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hex_page_scheduler
//   Directed self-checking bench for hex_page_scheduler with small timing
//   parameters (debounce 4, auto period 16, heartbeat MSB 3).
// -----------------------------------------------------------------------------
module tb_hex_page_scheduler;

  logic        CLOCK_50;
  logic        HRESETn;
  logic        key_n;
  logic        auto_en;
  logic [31:0] oPort;
  logic [31:0] iPort;
  logic        LOCKUP;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [1:0]  page;

  int checks_r;
  int failures_r;
  int cyc_r;

  hex_page_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (16),
    .HB_MSB         (3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .HRESETn (HRESETn),
    .key_n   (key_n),
    .auto_en (auto_en),
    .oPort   (oPort),
    .iPort   (iPort),
    .LOCKUP  (LOCKUP),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .HEX4    (HEX4),
    .HEX5    (HEX5),
    .page    (page)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Edges since reset release, used to predict the heartbeat digit.
  always @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) cyc_r <= 0;
    else          cyc_r <= cyc_r + 1;
  end

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press_key(input int hold);
    key_n = 1'b0;
    cycles(hold);
    key_n = 1'b1;
    cycles(12);
  endtask

  task automatic wait_page_change(input logic [1:0] prev, input int budget, output int n);
    n = 0;
    while (page === prev && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  function automatic logic [34:0] digits();
    return {HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] v;
    checks_r   = 0;
    failures_r = 0;
    HRESETn = 1'b0;
    key_n   = 1'b1;
    auto_en = 1'b0;
    oPort   = 32'h1234_5678;
    iPort   = 32'h0000_0000;
    LOCKUP  = 1'b0;

    // 1: reset state, page 0 content, heartbeat
    #25;
    check_eq("rst_digits", {5'd0, digits()}, {5'd0, {5{7'h7F}}});
    check_eq("rst_hex5", {33'd0, HEX5}, {33'd0, 7'h7F});
    check_eq("rst_page", {38'd0, page}, 40'd0);
    @(negedge CLOCK_50);
    HRESETn = 1'b1;
    cycles(1);
    check_eq("p0_digits", {5'd0, digits()}, {5'd0, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    check_eq("p0_page", {38'd0, page}, 40'd0);
    for (int i = 0; i < 20; i++) begin
      v = 4'(cyc_r - 1);
      check_eq("heartbeat", {33'd0, HEX5}, {33'd0, ((v[3] & v[1]) ? 7'h23 : 7'h7F)});
      cycles(1);
    end

    // 2: short glitch does not advance, long press advances exactly once
    key_n = 1'b0;
    cycles(2);
    key_n = 1'b1;
    cycles(12);
    check_eq("glitch_no_adv", {38'd0, page}, 40'd0);
    press_key(20);
    check_eq("press_page1", {38'd0, page}, 40'd1);
    check_eq("p1_digits", {5'd0, digits()}, {5'd0, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30});
    oPort = 32'hABC1_2345;
    cycles(1);
    check_eq("p1_latency", {5'd0, digits()}, {5'd0, 7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46});

    // 3: auto rotate every 16 cycles; coincident press and auto advance once
    auto_en = 1'b1;
    wait_page_change(2'd1, 40, n);
    check_eq("auto_first_bound", {39'd0, (n < 40)}, 40'd1);
    check_eq("auto_page2", {38'd0, page}, 40'd2);
    wait_page_change(2'd2, 40, n);
    check_eq("auto_period_a", 40'(n), 40'd16);
    check_eq("auto_page0", {38'd0, page}, 40'd0);
    wait_page_change(2'd0, 40, n);
    check_eq("auto_period_b", 40'(n), 40'd16);
    check_eq("auto_page1", {38'd0, page}, 40'd1);
    // press pulse is timed to land on the 16th cycle after this advance
    cycles(8);
    key_n = 1'b0;
    cycles(7);
    check_eq("coinc_before", {38'd0, page}, 40'd1);
    cycles(1);
    check_eq("coinc_single", {38'd0, page}, 40'd2);
    key_n = 1'b1;
    wait_page_change(2'd2, 40, n);
    check_eq("coinc_restart", 40'(n), 40'd16);
    check_eq("coinc_next_page", {38'd0, page}, 40'd0);
    auto_en = 1'b0;
    cycles(30);
    check_eq("auto_off_hold", {38'd0, page}, 40'd0);

    // 4: status priority and page 2 content
    oPort  = 32'hFFFF_FFFF;
    LOCKUP = 1'b1;
    cycles(1);
    check_eq("lockup_L", {33'd0, HEX5}, {33'd0, 7'h47});
    LOCKUP = 1'b0;
    cycles(1);
    check_eq("invalid_E", {33'd0, HEX5}, {33'd0, 7'h06});
    press_key(10);
    press_key(10);
    check_eq("page2_reached", {38'd0, page}, 40'd2);
    iPort = 32'h0000_03FF;
    cycles(1);
    check_eq("p2_digits", {5'd0, digits()}, {5'd0, 7'h40, 7'h40, 7'h30, 7'h0E, 7'h0E});

    // 5: asynchronous reset mid-debounce, held key must be re-pressed
    key_n = 1'b0;
    cycles(3);
    #5;
    HRESETn = 1'b0;
    #1;
    check_eq("async_rst_digits", {5'd0, digits()}, {5'd0, {5{7'h7F}}});
    check_eq("async_rst_hex5", {33'd0, HEX5}, {33'd0, 7'h7F});
    check_eq("async_rst_page", {38'd0, page}, 40'd0);
    cycles(2);
    HRESETn = 1'b1;
    cycles(30);
    check_eq("held_no_adv", {38'd0, page}, 40'd0);
    key_n = 1'b1;
    cycles(12);
    press_key(12);
    check_eq("repress_adv", {38'd0, page}, 40'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
